// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: initial hash value, FSM states, round functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  // H0 occupies [255:224], H7 occupies [31:0]
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word sliding window, filled serially during
// load and self-extending during rounds. w_t is always the oldest entry.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] w_in,
  output logic [31:0] w_t
);

  logic [31:0] win [16];
  logic [31:0] w_new;
  logic [31:0] fill;

  // Window holds W[t..t+15] during rounds, so the expanded word W[t+16]
  // comes from fixed taps 14, 9, 1 and 0.
  always_comb begin
    w_new = small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];
    fill  = load ? w_in : w_new;
  end

  // Shift the window by one word per accepted load or per round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
    end else if (load || shift) begin
      for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= fill;
    end
  end

  assign w_t = win[0];

endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression core: serial block load, 64 single-cycle rounds,
// chaining-value accumulation, with an external K lookup via k_idx/k_in.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         first_block,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic [6:0]   k_idx,
  input  logic [31:0]  k_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  state_t      state, nxt;
  logic [3:0]  wcnt;
  logic [5:0]  t;
  logic [31:0] hv [8];
  logic [31:0] wk [8];
  logic [31:0] w_t;
  logic [31:0] t1, t2;

  sha256_msg_schedule u_sched (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ST_LOAD && w_valid),
    .shift (state == ST_ROUND),
    .w_in  (w_data),
    .w_t   (w_t)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_LOAD;
      ST_LOAD:  if (w_valid && wcnt == 4'd15) nxt = ST_ROUND;
      ST_ROUND: if (t == 6'd63) nxt = ST_FINAL;
      ST_FINAL: nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Round arithmetic on the working variables a..h (wk[0]..wk[7]).
  always_comb begin
    t1 = wk[7] + big_s1(wk[4]) + ch(wk[4], wk[5], wk[6]) + k_in + w_t;
    t2 = big_s0(wk[0]) + maj(wk[0], wk[1], wk[2]);
  end

  // Datapath: chaining value, working variables and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        hv[i] <= '0;
        wk[i] <= '0;
      end
      wcnt <= '0;
      t    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wcnt <= '0;
          t    <= '0;
          if (start && first_block)
            for (int unsigned i = 0; i < 8; i++) hv[i] <= IV[255-32*i -: 32];
        end
        ST_LOAD: begin
          if (w_valid) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
              for (int unsigned i = 0; i < 8; i++) wk[i] <= hv[i];
              t <= '0;
            end
          end
        end
        ST_ROUND: begin
          wk[7] <= wk[6];
          wk[6] <= wk[5];
          wk[5] <= wk[4];
          wk[4] <= wk[3] + t1;
          wk[3] <= wk[2];
          wk[2] <= wk[1];
          wk[1] <= wk[0];
          wk[0] <= t1 + t2;
          t     <= t + 6'd1;
        end
        ST_FINAL: begin
          for (int unsigned i = 0; i < 8; i++) hv[i] <= hv[i] + wk[i];
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from state so reset clears them at once.
  always_comb begin
    w_ready = (state == ST_LOAD);
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    k_idx   = (state == ST_ROUND) ? {1'b0, t} : '0;
    digest  = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  end

endmodule
